load_store_unit: RTL and testbench

- Sits directly downstream of the five-stage datapath's memory stage.
- Consumes its data-memory request (address, function, mask type, store data) and turns it into a word-aligned bus transaction with byte enables.
- Returns sign- or zero-extended load data, and raises the cache-miss stall that freezes the pipeline until the access completes.
- Replaces the ideal single-cycle data memory model with a variable-latency handshake.

---
 rtl/load_store_unit_pkg.sv | 43 ++++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit_align.sv | 52 +++++
 rtl/load_store_unit.sv | 106 ++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types and constants for the load/store unit
package load_store_unit_pkg;

  localparam int LSU_ADDR_W      = 32;
  localparam int LSU_DATA_W      = 32;
  localparam int LSU_LATENCY_MIN = 3;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd5,
    MT_HU = 3'd6
  } mem_mask_t;

  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } mem_fcn_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  typedef struct packed {
    logic                  req_ready;
    logic                  resp_valid;
    logic [LSU_DATA_W-1:0] rdata;
  } data_bus_in_t;

  typedef struct packed {
    logic                    req_valid;
    logic [LSU_ADDR_W-1:0]   addr;
    logic                    we;
    logic [LSU_DATA_W/8-1:0] be;
    logic [LSU_DATA_W-1:0]   wdata;
  } data_bus_out_t;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-aligned data bus between the load/store unit and memory
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    bus_req_valid;
  logic                    bus_req_ready;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic                    bus_we;
  logic [DATA_WIDTH/8-1:0] bus_be;
  logic [DATA_WIDTH-1:0]   bus_wdata;
  logic                    bus_resp_valid;
  logic [DATA_WIDTH-1:0]   bus_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_req_ready, bus_resp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_req_ready, bus_resp_valid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - misalignment check, store lane placement and load extension
module load_store_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_typ,
  input  logic        st_we,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_typ,
  input  logic [31:0] ld_rdata,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_value
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Anything not byte or half (including MT_X) behaves as a full word.
  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = st_data;
    case (st_typ)
      MT_B, MT_BU: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      MT_H, MT_HU: begin
        misaligned = st_off[0];
        be         = 4'b0011 << st_off;
        wdata      = {2{st_data[15:0]}};
      end
      default: misaligned = (st_off != 2'b00);
    endcase
    if (!st_we) be = 4'b1111;
  end

  always_comb begin
    ld_byte  = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_half  = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_value = ld_rdata;
    case (ld_typ)
      MT_B:    ld_value = {{24{ld_byte[7]}}, ld_byte};
      MT_BU:   ld_value = {24'b0, ld_byte};
      MT_H:    ld_value = {{16{ld_half[15]}}, ld_half};
      MT_HU:   ld_value = {16'b0, ld_half};
      default: ld_value = ld_rdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage request to variable-latency bus adapter with pipeline stall
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = LSU_ADDR_W,
  parameter int DATA_WIDTH = LSU_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_fcn,
  input  logic [2:0]            req_typ,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  stall,
  output logic                  misaligned,
  load_store_unit_if.master     bus
);
  lsu_state_t    state, state_nxt;
  data_bus_out_t bus_q;
  data_bus_in_t  bus_in;
  logic [1:0]    lat_off;
  logic [2:0]    lat_typ;
  logic          accept;
  logic          req_mis;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   ld_value;

  assign bus_in = '{req_ready: bus.bus_req_ready, resp_valid: bus.bus_resp_valid, rdata: bus.bus_rdata};

  assign bus.bus_req_valid = bus_q.req_valid;
  assign bus.bus_addr      = bus_q.addr;
  assign bus.bus_we        = bus_q.we;
  assign bus.bus_be        = bus_q.be;
  assign bus.bus_wdata     = bus_q.wdata;

  load_store_align u_align (
    .st_off     (req_addr[1:0]),
    .st_typ     (req_typ),
    .st_we      (req_fcn),
    .st_data    (req_data),
    .ld_off     (lat_off),
    .ld_typ     (lat_typ),
    .ld_rdata   (bus_in.rdata),
    .misaligned (req_mis),
    .be         (al_be),
    .wdata      (al_wdata),
    .ld_value   (ld_value)
  );

  assign misaligned = (state == IDLE) && req_valid && req_mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A killed request (req_valid low at the response) skips DONE and drops its result.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: if (req_valid && !req_mis) begin
        stall     = 1'b1;
        accept    = 1'b1;
        state_nxt = REQ;
      end
      REQ: begin
        stall = req_valid;
        if (bus_in.req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        stall = req_valid;
        if (bus_in.resp_valid) state_nxt = req_valid ? DONE : IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q     <= '0;
      lat_off   <= 2'b00;
      lat_typ   <= 3'b000;
      resp_data <= '0;
    end else begin
      if (accept) begin
        bus_q.req_valid <= 1'b1;
        bus_q.addr      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        bus_q.we        <= req_fcn;
        bus_q.be        <= al_be;
        bus_q.wdata     <= al_wdata;
        lat_off         <= req_addr[1:0];
        lat_typ         <= req_typ;
      end else if (state == REQ && bus_in.req_ready) begin
        bus_q.req_valid <= 1'b0;
      end
      if (state == WAIT && bus_in.resp_valid && req_valid && !bus_q.we)
        resp_data <= ld_value;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_fcn;
  logic [2:0]  req_typ;
  logic [31:0] req_data;
  logic [31:0] resp_data;
  logic        stall;
  logic        misaligned;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_fcn    (req_fcn),
    .req_typ    (req_typ),
    .req_data   (req_data),
    .resp_data  (resp_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus        (bus)
  );

  typedef struct {
    logic        mis;
    logic [31:0] data;
  } resp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  resp_exp_t   resp_q[$];
  bus_exp_t    bus_q[$];
  resp_exp_t   mon_e;
  int          checks = 0;
  int          errors = 0;
  int          slave_delay = 0;
  int          slave_resp_delay = 0;
  logic [31:0] slave_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: ready after slave_delay cycles, response slave_resp_delay cycles after acceptance.
  initial begin
    int req_cnt;
    int resp_cnt;
    req_cnt = 0;
    resp_cnt = 0;
    bus.bus_req_ready  = 1'b0;
    bus.bus_resp_valid = 1'b0;
    bus.bus_rdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.bus_resp_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus.bus_resp_valid = 1'b1;
          bus.bus_rdata      = slave_rdata;
        end
      end
      if (bus.bus_req_ready) begin
        bus.bus_req_ready = 1'b0;
        if (slave_resp_delay == 0) begin
          bus.bus_resp_valid = 1'b1;
          bus.bus_rdata      = slave_rdata;
        end else begin
          resp_cnt = slave_resp_delay;
        end
      end else if (bus.bus_req_valid) begin
        if (req_cnt == slave_delay) begin
          bus.bus_req_ready = 1'b1;
          req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && req_valid && !stall) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=completion required=none");
      end else begin
        mon_e = resp_q.pop_front();
        chk("resp_misaligned", {31'b0, misaligned}, {31'b0, mon_e.mis});
        if (mon_e.mis) chk("mis_no_bus", {31'b0, bus.bus_req_valid}, 32'd0);
        else           chk("resp_data", resp_data, mon_e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus.bus_req_valid) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected actual=request addr=%h required=none", bus.bus_addr);
      end else begin
        chk("bus_addr", bus.bus_addr, bus_q[0].addr);
        chk("bus_we", {31'b0, bus.bus_we}, {31'b0, bus_q[0].we});
        chk("bus_be", {28'b0, bus.bus_be}, {28'b0, bus_q[0].be});
        if (bus_q[0].we) chk("bus_wdata", bus.bus_wdata, bus_q[0].wdata);
        if (req_valid) chk("bus_stall", {31'b0, stall}, 32'd1);
        if (bus.bus_req_ready) void'(bus_q.pop_front());
      end
    end
  end

  task automatic access(input logic [31:0] addr, input logic fcn, input logic [2:0] typ,
                        input logic [31:0] data, input logic [31:0] rdata, input int rdly,
                        input logic [31:0] exp_data, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input int exp_stall);
    bus_exp_t  b;
    resp_exp_t r;
    int        n;
    slave_rdata = rdata;
    slave_delay = rdly;
    b.addr  = {addr[31:2], 2'b00};
    b.we    = fcn;
    b.be    = exp_be;
    b.wdata = exp_wdata;
    bus_q.push_back(b);
    r.mis  = 1'b0;
    r.data = exp_data;
    resp_q.push_back(r);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = addr;
    req_fcn   = fcn;
    req_typ   = typ;
    req_data  = data;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk("stall_cycles", n, exp_stall);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic mis_access(input logic [31:0] addr, input logic [2:0] typ);
    resp_exp_t r;
    r.mis  = 1'b1;
    r.data = '0;
    resp_q.push_back(r);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = addr;
    req_fcn   = 1'b0;
    req_typ   = typ;
    req_data  = '0;
    @(negedge clk);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_state", {30'b0, dut.state}, {30'b0, IDLE});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus_exp_t b;
    int       bad;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_fcn   = 1'b0;
    req_typ   = MT_W;
    req_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    chk("rst_bus_valid", {31'b0, bus.bus_req_valid}, 32'd0);
    chk("rst_bus_be", {28'b0, bus.bus_be}, 32'd0);
    chk("rst_bus_addr", bus.bus_addr, 32'd0);

    access(32'h100, 1'b0, MT_W,  32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'b1111, 32'h0, LSU_LATENCY_MIN);
    access(32'h103, 1'b0, MT_B,  32'h0,        32'h80FF0000, 0, 32'hFFFFFF80, 4'b1111, 32'h0, 3);
    access(32'h103, 1'b0, MT_BU, 32'h0,        32'h80FF0000, 0, 32'h00000080, 4'b1111, 32'h0, 3);
    access(32'h202, 1'b1, MT_H,  32'h1234ABCD, 32'h55555555, 0, 32'h00000080, 4'b1100, 32'hABCDABCD, 3);
    mis_access(32'h101, MT_W);
    access(32'h102, 1'b0, MT_H,  32'h0,        32'h80017FFF, 5, 32'hFFFF8001, 4'b1111, 32'h0, 8);
    access(32'h305, 1'b1, MT_B,  32'h000000A5, 32'h0,        0, 32'hFFFF8001, 4'b0010, 32'hA5A5A5A5, 3);
    access(32'h100, 1'b0, MT_HU, 32'h0,        32'h1234F00D, 0, 32'h0000F00D, 4'b1111, 32'h0, 3);
    mis_access(32'h103, MT_H);
    access(32'h104, 1'b0, MT_X,  32'h0,        32'h01020304, 0, 32'h01020304, 4'b1111, 32'h0, 3);

    // Killed load: the bus access completes but its data never reaches resp_data.
    slave_rdata = 32'hCAFEF00D;
    b.addr = 32'h400; b.we = 1'b0; b.be = 4'b1111; b.wdata = '0;
    bus_q.push_back(b);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h400; req_fcn = 1'b0; req_typ = MT_W;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("kill_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("kill_state", {30'b0, dut.state}, {30'b0, IDLE});
    chk("kill_resp_hold", resp_data, 32'h01020304);

    // Reset while waiting for a delayed response, which then arrives in IDLE.
    slave_resp_delay = 3;
    slave_rdata = 32'h11112222;
    b.addr = 32'h500;
    bus_q.push_back(b);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h500; req_fcn = 1'b0; req_typ = MT_W;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_state", {30'b0, dut.state}, {30'b0, WAIT});
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_wait_bus_valid", {31'b0, bus.bus_req_valid}, 32'd0);
    chk("rst_wait_resp", resp_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (dut.state != IDLE) bad++;
    end
    chk("late_resp_state_stray", bad, 32'd0);
    chk("late_resp_data", resp_data, 32'd0);
    chk("late_resp_bus_valid", {31'b0, bus.bus_req_valid}, 32'd0);
    slave_resp_delay = 0;

    chk("resp_q_empty", resp_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
